// File: rtl/usr_serial_ctrl.sv
// Command sequencer for a universal shift register: drives select, fill and load
// inputs to exchange a word serially, load it, or read it back over valid/ready.
module usr_serial_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             ser_en,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [1:0]       usr_sel,
    output logic             usr_s_left,
    output logic             usr_s_right,
    output logic [WIDTH-1:0] usr_p_in,
    input  logic [WIDTH-1:0] usr_q,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [1:0] OP_XCHG_MSB = 2'b00;
    localparam logic [1:0] OP_XCHG_LSB = 2'b01;
    localparam logic [1:0] OP_LOAD     = 2'b10;
    localparam logic [1:0] OP_READ     = 2'b11;

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_LEFT  = 2'b01;
    localparam logic [1:0] SEL_RIGHT = 2'b10;
    localparam logic [1:0] SEL_LOAD  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_reg, state_next;
    logic [1:0]       op_reg, op_next;
    logic [WIDTH-1:0] data_reg, data_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic in_idle;
    logic in_shift;
    logic in_resp;
    logic accept;
    logic shift_fire;
    logic last_bit;

    assign in_idle    = (state_reg == ST_IDLE);
    assign in_shift   = (state_reg == ST_SHIFT);
    assign in_resp    = (state_reg == ST_RESP);
    assign accept     = cmd_valid && in_idle;
    assign shift_fire = in_shift && ser_en;
    assign last_bit   = (cnt_reg == CNT_LAST);

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        data_next  = data_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    op_next    = cmd_op;
                    data_next  = cmd_data;
                    state_next = (cmd_op == OP_READ) ? ST_RESP : ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_next   = '0;
                state_next = (op_reg == OP_LOAD) ? ST_RESP : ST_SHIFT;
            end
            ST_SHIFT: begin
                // Stalls on ser_en low indefinitely; the bit clock owner decides pacing.
                if (ser_en) begin
                    if (last_bit) begin
                        cnt_next   = '0;
                        state_next = ST_RESP;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            op_reg    <= OP_XCHG_MSB;
            data_reg  <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            data_reg  <= data_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        usr_sel = SEL_HOLD;
        if (state_reg == ST_LOAD) begin
            usr_sel = SEL_LOAD;
        end else if (shift_fire) begin
            usr_sel = (op_reg == OP_XCHG_LSB) ? SEL_RIGHT : SEL_LEFT;
        end
    end

    // Transmit bit is the one about to fall off the end being shifted away from.
    always_comb begin
        ser_out = 1'b0;
        if (shift_fire) begin
            ser_out = (op_reg == OP_XCHG_LSB) ? usr_q[0] : usr_q[WIDTH-1];
        end
    end

    assign ser_valid   = shift_fire;
    assign usr_s_left  = ser_in;
    assign usr_s_right = ser_in;
    assign usr_p_in    = data_reg;
    assign cmd_ready   = in_idle;
    assign busy        = !in_idle;
    assign rsp_valid   = in_resp;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rsp
            assign rsp_data[gi] = usr_q[gi] & in_resp;
        end
    endgenerate

endmodule

// File: doc/usr_serial_ctrl.md
Name: usr_serial_ctrl

Overview:
Sequencer for the team's 4-bit universal shift register (hold/shift-left/shift-right/load via 2-bit select). It accepts commands over a valid/ready interface and drives the register's select, serial-fill and parallel-load inputs. It turns the register into a full-duplex serializer/deserializer, or uses it for simple parallel load/read, and returns results over a valid/ready response interface. It sits between a host/bus-side command source and the shift register instance.

Parameters:
WIDTH, 4, data width of the controlled shift register
CNT_W, 3, bit counter width, must hold 0..WIDTH-1 (clog2(WIDTH)+1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept command (high only in IDLE)
cmd_op  in  2  00 exchange MSB-first (shift left), 01 exchange LSB-first (shift right), 10 load-only, 11 read
cmd_data  in  WIDTH  parallel word for exchange/load
ser_en  in  1  bit-clock enable; a shift occurs only in cycles where it is high
ser_in  in  1  serial receive bit
ser_out  out  1  serial transmit bit
ser_valid  out  1  ser_out is valid and is consumed at this edge
rsp_valid  out  1  response present
rsp_ready  in  1  response consumer ready
rsp_data  out  WIDTH  response word
usr_sel  out  2  to register select: 00 hold, 01 left, 10 right, 11 load
usr_s_left  out  1  to register left-shift fill bit (enters bit 0)
usr_s_right  out  1  to register right-shift fill bit (enters bit WIDTH-1)
usr_p_in  out  WIDTH  to register parallel load data
usr_q  in  WIDTH  register parallel output
busy  out  1  state != IDLE

Behaviour:
- Registered state: state, op_q, data_q, cnt. All usr_*, ser_*, rsp_*, cmd_ready and busy outputs are combinational from registered state plus usr_q/ser_in/ser_en.
- Reset (rst high at edge): state=IDLE, op_q=0, data_q=0, cnt=0.
  - Resulting outputs: cmd_ready=1, busy=0, rsp_valid=0, ser_valid=0, usr_sel=00, usr_p_in=0, ser_out=0.
  - The controller never clears the register itself; the system reset covers it.
- States: IDLE, LOAD, SHIFT, RESP.
- IDLE:
  - usr_sel=00.
  - On cmd_valid&cmd_ready, capture op_q=cmd_op and data_q=cmd_data.
  - Next state: op 00/01/10 -> LOAD; op 11 -> RESP.
- LOAD (exactly 1 cycle):
  - usr_sel=11, usr_p_in=data_q.
  - Next state: op 10 -> RESP; op 00/01 -> SHIFT with cnt=0.
- SHIFT:
  - ser_en=0: usr_sel=00, ser_valid=0, cnt holds; no timeout.
  - ser_en=1: usr_sel=01 (op 00) or 10 (op 01), ser_valid=1, cnt++.
  - ser_out = usr_q[WIDTH-1] for op 00, usr_q[0] for op 01. Drive 0 when ser_valid=0.
  - usr_s_left = usr_s_right = ser_in in all states; only the selected direction matters.
  - On an enabled cycle with cnt==WIDTH-1 -> RESP, cnt=0.
- RESP:
  - usr_sel=00, rsp_valid=1, rsp_data=usr_q.
  - rsp_data is stable while rsp_valid && !rsp_ready (register held).
  - On rsp_valid&rsp_ready -> IDLE. The next command can be accepted one cycle later; no same-cycle overlap.
- Latency, with ser_en tied high:
  - exchange: rsp_valid rises WIDTH+2 edges after the accept edge.
  - load-only: 2 edges.
  - read: 1 edge.
- Exchange semantics: after WIDTH shifts the register holds the received bits.
  - Left: first received bit ends in MSB.
  - Right: first received bit ends in LSB.
- Boundaries:
  - cmd_valid outside IDLE is ignored; cmd_ready=0.
  - ser_en is ignored outside SHIFT.
  - rsp_ready outside RESP is ignored.
  - rst in any state aborts: no response is issued and ser_valid drops at the next edge.
  - cnt never exceeds WIDTH-1.
  - usr_sel=11 only in LOAD; 01/10 only in enabled SHIFT cycles.

Test Plan:
- Reset, then idle: cmd_ready=1, busy=0, usr_sel=00 every cycle; no rsp_valid.
- WIDTH=4, op 00, data 1011, ser_en=1, ser_in 1,0,0,1 -> ser_out 1,0,1,1 over 4 consecutive ser_valid cycles; rsp_valid 6 edges after accept; rsp_data 1001.
- op 01, data 1011, ser_in 1,0,0,0 -> ser_out 1,1,0,1; rsp_data 0001.
- op 00 with ser_en pattern 1,0,0,1,1,0,1 -> exactly 4 shifts; usr_sel=00 and ser_valid=0 on disabled cycles; same ser_out/rsp_data as the unstalled case.
- op 10, data 0110 -> rsp_data 0110 after 2 edges; then op 11 -> rsp_data 0110 after 1 edge. Hold rsp_ready low 3 cycles -> rsp_valid and rsp_data stable, cmd_ready=0.
- rst asserted after 2 shifts of an exchange -> next cycle state IDLE, cmd_ready=1, ser_valid=0, no rsp_valid; a following op 11 completes normally.
